dma_port_arbiter: RTL and testbench

//  Shares the single HPS Avalon-MM DMA master between the RX path (packet write bursts to DDR) and the TX path (packet read bursts from DDR).

---
 rtl/dma_port_arbiter_pkg.sv | 28 ++
 rtl/dma_beat_counter.sv | 30 +++
 rtl/dma_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dma_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_port_arbiter_pkg.sv
// Shared types and default widths for the DMA port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dma_port_arbiter_pkg;

  localparam int ARM_INTF_WIDTH  = 64;
  localparam int BURST_CNT_WIDTH = 5;
  localparam int DMA_ADDR_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_CMD   = 2'd2,
    ST_RD_DATA  = 2'd3
  } dma_arb_state_t;

  typedef enum logic {
    GNT_RX = 1'b0,
    GNT_TX = 1'b1
  } dma_grant_t;

  // Burst command captured at grant; zero while the arbiter is idle.
  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0]  addr;
    logic [BURST_CNT_WIDTH-1:0] bcnt;
  } dma_burst_req_t;

endpackage

// File: rtl/dma_beat_counter.sv
// Remaining-beat counter for one burst: loaded at grant, decremented per beat.
// Latency: last flag is combinational from the registered count.
// Backpressure: none; beats are counted only when the caller signals them.
module dma_beat_counter #(
  parameter int BCNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BCNT_W-1:0] load_val,
  input  logic              beat,
  output logic              last
);

  logic [BCNT_W-1:0] remaining;

  // Load on grant, count down on each transferred beat, never wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (beat && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == BCNT_W'(1));

endmodule

// File: rtl/dma_port_arbiter.sv
// Round-robin, burst-granular arbiter sharing one Avalon-MM DMA master between RX writes and TX reads.
// Latency: request seen in cycle N -> first bus command in N+1; read data forwarded combinationally.
// Backpressure: avm_waitrequest stalls write beats/read command; bursts never abort. Stats under DMA_ARB_STATS_EN.
module dma_port_arbiter
  import dma_port_arbiter_pkg::*;
#(
  parameter int DATA_W = ARM_INTF_WIDTH,
  parameter int BCNT_W = BURST_CNT_WIDTH,
  parameter int ADDR_W = DMA_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_req,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [BCNT_W-1:0] rx_bcnt,
  input  logic [DATA_W-1:0] rx_wdata,
  output logic              rx_beat_ack,
  output logic              rx_done,
  input  logic              tx_req,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [BCNT_W-1:0] tx_bcnt,
  output logic [DATA_W-1:0] tx_rdata,
  output logic              tx_rvalid,
  output logic              tx_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BCNT_W-1:0] avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              arb_busy,
  output logic              protocol_err,
  output logic [31:0]       rx_grant_cnt,
  output logic [31:0]       tx_grant_cnt
);

  dma_arb_state_t state;
  dma_grant_t     last_grant;
  dma_burst_req_t burst_q;
  logic           rx_done_q;
  logic           tx_zero_done_q;
  logic           perr_q;

  logic              rx_ok, tx_ok;
  logic              grant_rx, grant_tx, grant_any;
  logic [BCNT_W-1:0] grant_bcnt;
  logic [ADDR_W-1:0] grant_addr;
  logic              wr_beat, rd_beat, last_beat;

  // A requester whose done pulse is visible this cycle still holds req; mask it so it is not regranted stale.
  assign rx_ok      = rx_req & ~rx_done_q;
  assign tx_ok      = tx_req & ~tx_zero_done_q;
  assign grant_rx   = (state == ST_IDLE) & rx_ok & (~tx_ok | (last_grant == GNT_TX));
  assign grant_tx   = (state == ST_IDLE) & tx_ok & ~grant_rx;
  assign grant_any  = grant_rx | grant_tx;
  assign grant_bcnt = grant_rx ? rx_bcnt : tx_bcnt;
  assign grant_addr = grant_rx ? rx_addr : tx_addr;

  assign wr_beat = (state == ST_WR_BURST) & ~avm_waitrequest;
  assign rd_beat = (state == ST_RD_DATA) & avm_readdatavalid;

  dma_beat_counter #(.BCNT_W(BCNT_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_any),
    .load_val (grant_bcnt),
    .beat     (wr_beat | rd_beat),
    .last     (last_beat)
  );

  // Arbitration FSM: grant, run the burst to completion, capture done pulses and protocol errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      last_grant     <= GNT_TX;
      burst_q        <= '0;
      rx_done_q      <= 1'b0;
      tx_zero_done_q <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      rx_done_q      <= 1'b0;
      tx_zero_done_q <= 1'b0;
      if (avm_readdatavalid && (state != ST_RD_DATA)) begin
        perr_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            last_grant <= grant_rx ? GNT_RX : GNT_TX;
            if (grant_bcnt == '0) begin
              // Empty burst: no bus cycle, just acknowledge and flag it.
              perr_q         <= 1'b1;
              rx_done_q      <= grant_rx;
              tx_zero_done_q <= grant_tx;
            end else begin
              burst_q.addr <= DMA_ADDR_WIDTH'(grant_addr);
              burst_q.bcnt <= BURST_CNT_WIDTH'(grant_bcnt);
              state        <= grant_rx ? ST_WR_BURST : ST_RD_CMD;
            end
          end
        end
        ST_WR_BURST: begin
          if (wr_beat && last_beat) begin
            rx_done_q <= 1'b1;
            burst_q   <= '0;
            state     <= ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (!avm_waitrequest) begin
            state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rd_beat && last_beat) begin
            burst_q <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign avm_address    = ADDR_W'(burst_q.addr);
  assign avm_burstcount = BCNT_W'(burst_q.bcnt);
  assign avm_write      = (state == ST_WR_BURST);
  assign avm_read       = (state == ST_RD_CMD);
  assign avm_writedata  = avm_write ? rx_wdata : '0;
  assign rx_beat_ack    = wr_beat;
  assign rx_done        = rx_done_q;
  assign tx_rvalid      = rd_beat;
  assign tx_rdata       = rd_beat ? avm_readdata : '0;
  assign tx_done        = (rd_beat & last_beat) | tx_zero_done_q;
  assign arb_busy       = (state != ST_IDLE);
  assign protocol_err   = perr_q;

`ifdef DMA_ARB_STATS_EN
  logic [31:0] rx_cnt_q, tx_cnt_q;

  // Grant statistics, empty bursts included; free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (grant_rx) rx_cnt_q <= rx_cnt_q + 32'd1;
      if (grant_tx) tx_cnt_q <= tx_cnt_q + 32'd1;
    end
  end

  assign rx_grant_cnt = rx_cnt_q;
  assign tx_grant_cnt = tx_cnt_q;
`else
  assign rx_grant_cnt = 32'd0;
  assign tx_grant_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Directed bench for dma_port_arbiter with a behavioural requester pair and Avalon slave.
// Inputs driven at the falling edge, outputs sampled 2ns later.
// Optional stats checked against DMA_ARB_STATS_EN.
module tb_dma_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_req, tx_req;
  logic [31:0] rx_addr, tx_addr;
  logic [4:0]  rx_bcnt, tx_bcnt;
  logic [63:0] rx_wdata;
  logic        rx_beat_ack, rx_done;
  logic [63:0] tx_rdata;
  logic        tx_rvalid, tx_done;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [63:0] avm_writedata;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        arb_busy, protocol_err;
  logic [31:0] rx_grant_cnt, tx_grant_cnt;

  dma_port_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .rx_req            (rx_req),
    .rx_addr           (rx_addr),
    .rx_bcnt           (rx_bcnt),
    .rx_wdata          (rx_wdata),
    .rx_beat_ack       (rx_beat_ack),
    .rx_done           (rx_done),
    .tx_req            (tx_req),
    .tx_addr           (tx_addr),
    .tx_bcnt           (tx_bcnt),
    .tx_rdata          (tx_rdata),
    .tx_rvalid         (tx_rvalid),
    .tx_done           (tx_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .arb_busy          (arb_busy),
    .protocol_err      (protocol_err),
    .rx_grant_cnt      (rx_grant_cnt),
    .tx_grant_cnt      (tx_grant_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // bench-side stimulus configuration and recorded observations
  int          rx_todo, tx_todo, rst_at;
  logic [31:0] wait_pat;
  int          gaps [8];
  int          cyc, rx_acks, wr_beats, wr_cycles, busy_cycles, first_wr, last_wr;
  int          tx_beats, last_rv, rx_done_n, tx_done_n, rx_done_cyc, tx_done_cyc;
  int          data_bad, addr_bad, done_bad, post_rst_bad;
  int          rd_left, rd_idx, gap_left, gi;
  int          order [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    cyc = 0; rx_acks = 0; wr_beats = 0; wr_cycles = 0; busy_cycles = 0;
    first_wr = -1; last_wr = -1; tx_beats = 0; last_rv = -1;
    rx_done_n = 0; tx_done_n = 0; rx_done_cyc = -1; tx_done_cyc = -1;
    data_bad = 0; addr_bad = 0; done_bad = 0; post_rst_bad = 0;
    rd_left = 0; rd_idx = 0; gap_left = 0; gi = 0;
    order.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_req = 1'b0; tx_req = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    rx_wdata = '0; rx_todo = 0; tx_todo = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
  endtask

  // one bus cycle per iteration: drive requesters and slave, then observe
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst             = (cyc == rst_at);
      rx_req          = (rx_todo > 0);
      tx_req          = (tx_todo > 0);
      rx_wdata        = 64'hA000 + 64'(rx_acks);
      avm_waitrequest = (cyc < 32) ? wait_pat[cyc[4:0]] : 1'b0;
      if (rd_left > 0 && gap_left == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 64'hB000 + 64'(rd_idx);
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
      #2;
      if (avm_write) wr_cycles++;
      if (arb_busy) busy_cycles++;
      if (avm_write && first_wr < 0) first_wr = cyc;
      if (avm_write && !avm_waitrequest) begin
        if (avm_writedata != 64'hA000 + 64'(wr_beats)) data_bad++;
        wr_beats++;
        last_wr = cyc;
      end
      if ((avm_write && (avm_address != rx_addr || avm_burstcount != rx_bcnt)) ||
          (avm_read  && (avm_address != tx_addr || avm_burstcount != tx_bcnt)) ||
          (!arb_busy && (avm_address != 32'd0 || avm_burstcount != 5'd0)))
        addr_bad++;
      if (rx_beat_ack) rx_acks++;
      if (tx_rvalid) begin
        if (tx_rdata != 64'hB000 + 64'(tx_beats)) data_bad++;
        tx_beats++;
        last_rv = cyc;
      end
      if (rx_done) begin
        rx_done_n++; rx_done_cyc = cyc; order.push_back(0);
        if (rx_todo > 0) rx_todo--;
      end
      if (tx_done) begin
        tx_done_n++; tx_done_cyc = cyc; order.push_back(1);
        if (!tx_rvalid && tx_bcnt != 5'd0) done_bad++;
        if (tx_todo > 0) tx_todo--;
      end
      if (cyc == rst_at + 1 &&
          (avm_write || avm_read || avm_address != 32'd0 || avm_burstcount != 5'd0 || arb_busy))
        post_rst_bad++;
      if (cyc == rst_at) begin
        rx_todo = 0; tx_todo = 0; rd_left = 0; gap_left = 0;
      end
      if (avm_readdatavalid) begin
        rd_left--; rd_idx++;
        gap_left = gaps[gi % 8];
        gi++;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (avm_read && !avm_waitrequest) begin
        rd_left  = int'(avm_burstcount);
        gap_left = 0;
      end
      cyc++;
    end
  endtask

  initial begin
    rst_at = -10;
    wait_pat = 32'h0;
    for (int i = 0; i < 8; i++) gaps[i] = 0;
    rx_addr = 32'h0; tx_addr = 32'h0; rx_bcnt = 5'd0; tx_bcnt = 5'd0;
    clear_rec();

    // reset state
    do_reset();
    check("rst_write",  64'(avm_write), 0);
    check("rst_read",   64'(avm_read), 0);
    check("rst_addr",   64'(avm_address), 0);
    check("rst_busy",   64'(arb_busy), 0);
    check("rst_perr",   64'(protocol_err), 0);
    check("rst_done",   64'({rx_done, tx_done}), 0);
    check("rst_stats",  64'({rx_grant_cnt, tx_grant_cnt}), 0);

    // 1: write burst of 4 with waitrequest on beat 2 for 2 cycles
    clear_rec();
    rx_addr = 32'h1000; rx_bcnt = 5'd4; wait_pat = 32'hC; rx_todo = 1;
    run(12);
    check("t1_first_wr",  64'(first_wr), 1);
    check("t1_last_wr",   64'(last_wr), 6);
    check("t1_wr_beats",  64'(wr_beats), 4);
    check("t1_acks",      64'(rx_acks), 4);
    check("t1_wr_cycles", 64'(wr_cycles), 6);
    check("t1_done_cyc",  64'(rx_done_cyc), 7);
    check("t1_done_n",    64'(rx_done_n), 1);
    check("t1_data",      64'(data_bad), 0);
    check("t1_addr",      64'(addr_bad), 0);

    // 2: simultaneous requests after reset alternate starting with RX
    do_reset();
    clear_rec();
    wait_pat = 32'h0;
    rx_addr = 32'h2000; rx_bcnt = 5'd2; tx_addr = 32'h3000; tx_bcnt = 5'd2;
    rx_todo = 2; tx_todo = 2;
    run(40);
    check("t2_n_bursts", 64'(order.size()), 4);
    if (order.size() == 4) begin
      check("t2_grant0", 64'(order[0]), 0);
      check("t2_grant1", 64'(order[1]), 1);
      check("t2_grant2", 64'(order[2]), 0);
      check("t2_grant3", 64'(order[3]), 1);
    end
    check("t2_rd_beats", 64'(tx_beats), 4);
    check("t2_data",     64'(data_bad), 0);
    check("t2_addr",     64'(addr_bad), 0);

    // 3: read burst of 8 with irregular readdatavalid gaps
    clear_rec();
    gaps[0] = 0; gaps[1] = 1; gaps[2] = 2; gaps[3] = 3;
    gaps[4] = 0; gaps[5] = 2; gaps[6] = 1; gaps[7] = 3;
    tx_addr = 32'h4000; tx_bcnt = 5'd8; tx_todo = 1;
    run(40);
    check("t3_rd_beats",  64'(tx_beats), 8);
    check("t3_data",      64'(data_bad), 0);
    check("t3_done_n",    64'(tx_done_n), 1);
    check("t3_done_last", 64'(tx_done_cyc), 64'(last_rv));
    check("t3_done_bad",  64'(done_bad), 0);
    check("t3_idle",      64'(arb_busy), 0);
    check("t3_addr",      64'(addr_bad), 0);
    check("t3_perr",      64'(protocol_err), 0);

    // 4: empty RX burst flags a sticky protocol error
    clear_rec();
    rx_bcnt = 5'd0; rx_todo = 1;
    run(6);
    check("t4_done_cyc",  64'(rx_done_cyc), 1);
    check("t4_done_n",    64'(rx_done_n), 1);
    check("t4_no_write",  64'(wr_cycles), 0);
    check("t4_no_busy",   64'(busy_cycles), 0);
    check("t4_perr",      64'(protocol_err), 1);
    clear_rec();
    tx_bcnt = 5'd2; tx_todo = 1;
    run(10);
    check("t4_tx_beats",  64'(tx_beats), 2);
    check("t4_perr_held", 64'(protocol_err), 1);
    do_reset();
    check("t4_perr_clr",  64'(protocol_err), 0);

    // 5: reset during beat 3 of a 6-beat write abandons the burst
    clear_rec();
    rx_addr = 32'h5000; rx_bcnt = 5'd6; rx_todo = 1; rst_at = 3;
    run(6);
    check("t5_wr_beats",  64'(wr_beats), 3);
    check("t5_post_rst",  64'(post_rst_bad), 0);
    check("t5_no_done",   64'(rx_done_n), 0);
    rst_at = -10;
    clear_rec();
    rx_bcnt = 5'd2; rx_todo = 1;
    run(10);
    check("t5_new_beats", 64'(wr_beats), 2);
    check("t5_new_done",  64'(rx_done_n), 1);
    check("t5_new_data",  64'(data_bad), 0);

    // 6: grant statistics (1 RX so far since reset, then 2 RX + 2 TX)
    clear_rec();
    rx_bcnt = 5'd2; tx_bcnt = 5'd2; rx_todo = 2; tx_todo = 2;
    run(40);
    check("t6_bursts", 64'(order.size()), 4);
`ifdef DMA_ARB_STATS_EN
    check("t6_rx_cnt", 64'(rx_grant_cnt), 3);
    check("t6_tx_cnt", 64'(tx_grant_cnt), 2);
`else
    check("t6_rx_cnt", 64'(rx_grant_cnt), 0);
    check("t6_tx_cnt", 64'(tx_grant_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
